bus_initiator: RTL

Initiator end of the daisy-chained core bus. Accepts host requests (address, data, read/write) on a valid/ready port and launches each as a one-cycle transaction at the head of the core chain. It watches the tail of the chain for the returning transactions and queues read results for the response encoder. It bounds the number of in-flight transactions, applies credit-based backpressure, and recovers from a broken chain with a timeout.

---
 rtl/bus_initiator.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// Initiator at the head of the daisy-chained core bus: launches host requests,
// tracks returns from the chain tail, queues read results and recovers dead chains.
module bus_initiator #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        req_addr_i,
    input  logic [15:0]                        req_data_i,
    input  logic                               req_rw_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    output logic [15:0]                        addr_o,
    output logic [15:0]                        wdata_o,
    output logic [15:0]                        rdata_o,
    output logic                               rw_o,
    output logic                               valid_o,
    input  logic [15:0]                        addr_i,
    input  logic [15:0]                        wdata_i,
    input  logic [15:0]                        rdata_i,
    input  logic                               rw_i,
    input  logic                               valid_i,
    output logic [15:0]                        resp_addr_o,
    output logic [15:0]                        resp_data_o,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic                               timeout_o,
    output logic                               stray_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   inflight_o
);

    localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FW = $clog2(RESP_DEPTH) + 1;
    localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = ((IW > FW) ? IW : FW) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timerNext;
    logic            w_timeoutFire;

    logic [IW-1:0]   r_inflight;
    logic [IW-1:0]   r_rdInflight;
    logic [IW-1:0]   w_inflightStep;
    logic [IW-1:0]   w_inflightNext;
    logic [IW-1:0]   w_rdInflightNext;

    logic [FW-1:0]   r_fifoCount;
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [31:0]     r_mem [RESP_DEPTH];

    logic [15:0]     r_addrO;
    logic [15:0]     r_wdataO;
    logic            r_rwO;
    logic            r_validO;
    logic            r_timeoutO;
    logic            r_strayO;

    logic            w_accept;
    logic            w_retActive;
    logic            w_retDec;
    logic            w_push;
    logic            w_pop;
    logic            w_stray;
    logic [SW-1:0]   w_credSum;
    logic            w_unused;

    assign w_unused = ^{wdata_i, 1'b0};

    // Read credit counts both reads still on the chain and results not yet popped.
    assign w_credSum   = SW'(r_rdInflight) + SW'(r_fifoCount);
    assign req_ready_o = rst_n && (r_state != RECOVER)
                       && (r_inflight < IW'(MAX_OUTSTANDING))
                       && (req_rw_i || (w_credSum < SW'(RESP_DEPTH)));

    assign w_accept    = req_valid_i && req_ready_o;
    assign w_retActive = valid_i && (r_state != RECOVER);
    assign w_retDec    = w_retActive && (r_inflight != '0);
    assign w_push      = w_retActive && !rw_i && (r_rdInflight != '0);
    assign w_stray     = w_retActive && ((r_inflight == '0) || (!rw_i && (r_rdInflight == '0)));
    assign w_pop       = resp_ready_i && (r_fifoCount != '0);

    always_comb begin
        w_inflightStep = r_inflight;
        if (w_accept && !w_retDec) begin
            w_inflightStep = r_inflight + 1'b1;
        end else if (!w_accept && w_retDec) begin
            w_inflightStep = r_inflight - 1'b1;
        end
        w_inflightNext = w_timeoutFire ? '0 : w_inflightStep;
    end

    always_comb begin
        w_rdInflightNext = r_rdInflight;
        if (w_accept && !req_rw_i && !w_push) begin
            w_rdInflightNext = r_rdInflight + 1'b1;
        end else if (!(w_accept && !req_rw_i) && w_push) begin
            w_rdInflightNext = r_rdInflight - 1'b1;
        end
        if (w_timeoutFire) begin
            w_rdInflightNext = '0;
        end
    end

    // The timer counts return-free BUSY cycles, then is reused to time RECOVER.
    always_comb begin
        w_stateNext   = r_state;
        w_timerNext   = r_timer;
        w_timeoutFire = 1'b0;
        case (r_state)
            IDLE: begin
                w_timerNext = '0;
                if (w_accept) begin
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                if (valid_i) begin
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
                if (!valid_i && (r_timer == TW'(TIMEOUT_CYCLES - 1))) begin
                    w_timeoutFire = 1'b1;
                    w_stateNext   = RECOVER;
                    w_timerNext   = '0;
                end else if (w_inflightStep == '0) begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end
            end
            RECOVER: begin
                if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_timerNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_inflight   <= '0;
            r_rdInflight <= '0;
            r_timeoutO   <= 1'b0;
            r_strayO     <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_timer      <= w_timerNext;
            r_inflight   <= w_inflightNext;
            r_rdInflight <= w_rdInflightNext;
            r_timeoutO   <= w_timeoutFire;
            r_strayO     <= w_stray;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_validO <= 1'b0;
            r_rwO    <= 1'b0;
            r_addrO  <= '0;
            r_wdataO <= '0;
        end else begin
            r_validO <= w_accept;
            if (w_accept) begin
                r_rwO    <= req_rw_i;
                r_addrO  <= req_addr_i;
                r_wdataO <= req_data_i;
            end
        end
    end

    // Response FIFO: pointers reset, storage does not; valid only while count is non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifoCount <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == AW'(RESP_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == AW'(RESP_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifoCount <= r_fifoCount + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifoCount <= r_fifoCount - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {addr_i, rdata_i};
        end
    end

    assign addr_o       = r_addrO;
    assign wdata_o      = r_wdataO;
    assign rdata_o      = '0;
    assign rw_o         = r_rwO;
    assign valid_o      = r_validO;
    assign resp_addr_o  = r_mem[r_rdPtr][31:16];
    assign resp_data_o  = r_mem[r_rdPtr][15:0];
    assign resp_valid_o = (r_fifoCount != '0);
    assign timeout_o    = r_timeoutO;
    assign stray_o      = r_strayO;
    assign inflight_o   = r_inflight;

endmodule
